// File: rtl/nn_sample_loader_if.sv
// Handshake and data bundle between the host/UART side, the loader and the classifier core.
// The master modport is the host/core side; the slave modport is the loader.
interface nn_sample_loader_if #(
  parameter int unsigned DATA_BYTES = 62
);
  logic [7:0]              s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [8*DATA_BYTES-1:0] reshaped_test_data;
  logic                    nn_start;
  logic [7:0]              nn_label;
  logic [7:0]              label_out;
  logic                    label_valid;
  logic                    label_ready;
  logic                    busy;

  modport master (
    output s_data, s_valid, nn_label, label_ready,
    input  s_ready, reshaped_test_data, nn_start, label_out, label_valid, busy
  );

  modport slave (
    input  s_data, s_valid, nn_label, label_ready,
    output s_ready, reshaped_test_data, nn_start, label_out, label_valid, busy
  );
endinterface

// File: rtl/nn_sample_loader.sv
// Byte-serial sample loader for the classifier core: assembles DATA_BYTES bytes into one flat
// vector (first byte in the LSBs), pulses nn_start, waits NN_LATENCY cycles, captures the label
// and hands it back over a valid/ready handshake.
module nn_sample_loader #(
  parameter int unsigned DATA_BYTES = 62,
  parameter int unsigned NN_LATENCY = 1200
) (
  input  logic               clk,
  input  logic               rst,
  nn_sample_loader_if.slave  bus
);

  localparam int unsigned CntW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned VecW  = 8 * DATA_BYTES;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t        LastByte = cnt_t'(DATA_BYTES - 1);
  localparam logic [15:0] LatLast  = 16'(NN_LATENCY - 1);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StResult} state_e;

  state_e            state_q, state_d;
  cnt_t              byte_cnt_q, byte_cnt_d;
  logic [15:0]       lat_cnt_q, lat_cnt_d;
  logic [VecW-1:0]   data_q, data_d;
  logic [7:0]        label_q, label_d;
  logic              nn_start_q, nn_start_d;
  logic              label_valid_q, label_valid_d;
  logic              init_q;
  logic              s_ready;

  // s_ready is held low while in reset and rises on the first edge after release.
  assign s_ready = init_q && (state_q == StLoad);

  // Next-state, counter and datapath update.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    data_d     = data_q;
    label_d    = label_q;
    unique case (state_q)
      StLoad: begin
        if (bus.s_valid && s_ready) begin
          for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (byte_cnt_q == cnt_t'(i)) data_d[8*i +: 8] = bus.s_data;
          end
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d = '0;
            state_d    = StStart;
          end else begin
            byte_cnt_d = byte_cnt_q + cnt_t'(1);
          end
        end
      end
      StStart: begin
        lat_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q + 16'd1;
        if (lat_cnt_q == LatLast) begin
          label_d = bus.nn_label;
          state_d = StResult;
        end
      end
      StResult: begin
        if (label_valid_q && bus.label_ready) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
    // Registered strobes track the state being entered, so they are high exactly while there.
    nn_start_d    = (state_d == StStart);
    label_valid_d = (state_d == StResult);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StLoad;
      byte_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      data_q        <= '0;
      label_q       <= '0;
      nn_start_q    <= 1'b0;
      label_valid_q <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      data_q        <= data_d;
      label_q       <= label_d;
      nn_start_q    <= nn_start_d;
      label_valid_q <= label_valid_d;
      init_q        <= 1'b1;
    end
  end

  // Output drive: handshake and busy decode from state only.
  always_comb begin
    bus.s_ready            = s_ready;
    bus.busy               = (state_q != StLoad);
    bus.reshaped_test_data = data_q;
    bus.nn_start           = nn_start_q;
    bus.label_out          = label_q;
    bus.label_valid        = label_valid_q;
  end

endmodule

// File: tb/tb_nn_sample_loader.sv
// Directed/randomised bench for nn_sample_loader. Two instances: one with the default 1200-cycle
// latency and one with latency 1 for back-to-back samples.
module tb_nn_sample_loader;
  localparam int unsigned DB   = 62;
  localparam int unsigned LatA = 1200;
  localparam int          W    = 8 * DB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] smp [DB];

  always #5 clk = ~clk;

  nn_sample_loader_if #(.DATA_BYTES(DB)) bus_a ();
  nn_sample_loader_if #(.DATA_BYTES(DB)) bus_b ();

  nn_sample_loader #(.DATA_BYTES(DB), .NN_LATENCY(LatA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  nn_sample_loader #(.DATA_BYTES(DB), .NN_LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference vector: byte 0 in the LSBs, last byte in the MSBs.
  function automatic logic [W-1:0] pack();
    logic [W-1:0] v;
    v = '0;
    for (int i = DB - 1; i >= 0; i--) v = {v[W-9:0], smp[i]};
    return v;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < DB; i++) smp[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom_range(255, 1));
  endtask

  // Drive nbytes of smp[] into instance A; mode 0 back-to-back, mode 1 toggling with random gaps.
  task automatic load_a(input int mode, input int nbytes, input string tag);
    int idx;
    int cyc;
    int bad;
    logic acc;
    idx = 0;
    cyc = 0;
    bad = 0;
    while (idx < nbytes && cyc < 2000) begin
      if (mode == 0) bus_a.s_valid = 1'b1;
      else bus_a.s_valid = (cyc % 2 == 0) && ($urandom_range(3) != 0);
      bus_a.s_data = bus_a.s_valid ? smp[idx] : 8'($urandom);
      if (bus_a.s_ready !== 1'b1 || bus_a.nn_start !== 1'b0 || bus_a.busy !== 1'b0) bad++;
      acc = bus_a.s_valid && bus_a.s_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    bus_a.s_valid = 1'b0;
    check({tag, "_load_done"}, 512'(idx), 512'(nbytes));
    check({tag, "_load_flags"}, 512'(bad), 512'd0);
  endtask

  // Entered in the cycle where nn_start is high; the following edge is the nn_start edge.
  task automatic wait_a(input logic [7:0] lbl, input string tag);
    logic [W-1:0] vec;
    int bad;
    vec = pack();
    bad = 0;
    for (int k = 0; k < int'(LatA); k++) begin
      bus_a.nn_label = ~lbl;
      tick();
      if (bus_a.label_valid !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.s_ready !== 1'b0 ||
          bus_a.nn_start !== 1'b0 || bus_a.reshaped_test_data !== vec) bad++;
    end
    check({tag, "_wait_flags"}, 512'(bad), 512'd0);
    bus_a.nn_label = lbl;
    tick();
    check({tag, "_label_valid"}, 512'(bus_a.label_valid), 512'd1);
    check({tag, "_label_out"}, 512'(bus_a.label_out), 512'(lbl));
    check({tag, "_busy_result"}, 512'(bus_a.busy), 512'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 512'(bus_a.reshaped_test_data), 512'd0);
    check({tag, "_label"}, 512'(bus_a.label_out), 512'd0);
    check({tag, "_flags"},
          512'({bus_a.s_ready, bus_a.nn_start, bus_a.label_valid, bus_a.busy}), 512'd0);
  endtask

  initial begin
    logic [W-1:0] vec;
    logic [7:0]   lbl;
    int           bad;
    int           idx;
    int           cyc;
    logic         acc;

    bus_a.s_data = '0; bus_a.s_valid = 1'b0; bus_a.nn_label = '0; bus_a.label_ready = 1'b0;
    bus_b.s_data = '0; bus_b.s_valid = 1'b0; bus_b.nn_label = '0; bus_b.label_ready = 1'b1;

    // Reset state.
    #12;
    check_zero("reset");
    rst = 1'b1;
    tick();
    check("reset_s_ready", 512'(bus_a.s_ready), 512'd1);

    // Test 1: bytes 0x01..0x3E back-to-back.
    fill(0);
    load_a(0, DB, "t1");
    vec = bus_a.reshaped_test_data;
    check("t1_vector", 512'(vec), 512'(pack()));
    check("t1_low_byte", 512'(vec[7:0]), 512'h01);
    check("t1_high_byte", 512'(vec[W-1 -: 8]), 512'h3e);
    check("t1_s_ready_low", 512'(bus_a.s_ready), 512'd0);
    check("t1_nn_start", 512'(bus_a.nn_start), 512'd1);

    // Test 2: label sampled 1200 edges after the nn_start edge.
    wait_a(8'h07, "t2");
    bus_a.nn_label = 8'h03;
    tick();
    check("t2_label_hold", 512'(bus_a.label_out), 512'h07);

    // Test 3: host stalls for 50 cycles, then accepts.
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      bus_a.nn_label = 8'($urandom);
      tick();
      if (bus_a.label_valid !== 1'b1 || bus_a.label_out !== 8'h07 || bus_a.s_ready !== 1'b0) bad++;
    end
    check("t3_stall", 512'(bad), 512'd0);
    bus_a.label_ready = 1'b1;
    tick();
    bus_a.label_ready = 1'b0;
    check("t3_label_valid_drop", 512'(bus_a.label_valid), 512'd0);
    check("t3_s_ready_back", 512'(bus_a.s_ready), 512'd1);
    check("t3_busy_drop", 512'(bus_a.busy), 512'd0);

    // Test 4: random bytes with toggling valid and gaps; label_ready held high.
    fill(1);
    load_a(1, DB, "t4");
    check("t4_vector", 512'(bus_a.reshaped_test_data), 512'(pack()));
    check("t4_nn_start", 512'(bus_a.nn_start), 512'd1);
    bus_a.label_ready = 1'b1;
    lbl = 8'($urandom_range(255, 1));
    wait_a(lbl, "t4");
    tick();
    check("t4_accept", 512'({bus_a.label_valid, bus_a.s_ready}), 512'b01);
    bus_a.label_ready = 1'b0;

    // Test 5a: asynchronous reset after 30 bytes, checked with no clock edge in between.
    fill(1);
    load_a(1, 30, "t5a");
    #2 rst = 1'b0;
    #1 check_zero("t5a_rst");
    #1 rst = 1'b1;
    tick();
    fill(0);
    load_a(0, DB, "t5b");
    check("t5b_vector", 512'(bus_a.reshaped_test_data), 512'(pack()));
    check("t5b_nn_start", 512'(bus_a.nn_start), 512'd1);

    // Test 5c: asynchronous reset in the middle of WAIT.
    for (int k = 0; k < 100; k++) tick();
    check("t5c_busy_before", 512'(bus_a.busy), 512'd1);
    #2 rst = 1'b0;
    #1 check_zero("t5c_rst");
    #1 rst = 1'b1;
    tick();
    check("t5c_s_ready", 512'(bus_a.s_ready), 512'd1);
    fill(0);
    load_a(0, DB, "t5d");
    check("t5d_vector", 512'(bus_a.reshaped_test_data), 512'(pack()));
    wait_a(8'h5a, "t5d");

    // Test 6: latency 1, two consecutive samples, label_ready tied high.
    for (int s = 0; s < 2; s++) begin
      fill(1);
      idx = 0;
      cyc = 0;
      while (idx < int'(DB) && cyc < 500) begin
        bus_b.s_valid = 1'b1;
        bus_b.s_data  = smp[idx];
        acc = bus_b.s_ready;
        tick();
        cyc++;
        if (acc) idx++;
      end
      bus_b.s_valid = 1'b0;
      check("t6_load_done", 512'(idx), 512'(DB));
      check("t6_vector", 512'(bus_b.reshaped_test_data), 512'(pack()));
      check("t6_nn_start", 512'(bus_b.nn_start), 512'd1);
      lbl = 8'($urandom);
      bus_b.nn_label = ~lbl;
      tick();
      check("t6_wait", 512'({bus_b.nn_start, bus_b.label_valid, bus_b.busy}), 512'b001);
      bus_b.nn_label = lbl;
      tick();
      check("t6_label_valid", 512'(bus_b.label_valid), 512'd1);
      check("t6_label_out", 512'(bus_b.label_out), 512'(lbl));
      bus_b.nn_label = ~lbl;
      tick();
      check("t6_back_to_load", 512'({bus_b.label_valid, bus_b.s_ready}), 512'b01);
      check("t6_label_hold", 512'(bus_b.label_out), 512'(lbl));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_sample_loader.md
Name: nn_sample_loader

Overview:
- Feeds the classifier core: takes a byte-serial valid/ready stream and assembles the flattened 496-bit test-sample vector.
- Pulses the core's start once the vector is complete, waits a fixed compute latency, then captures the 8-bit label.
- Returns the label to the host over a valid/ready output handshake.
- Sits between the host/UART side and the neural-network top level. It is the producer of reshaped_test_data/start and the consumer of label.

Parameters:
- DATA_BYTES, 62, number of bytes per sample; vector width is 8*DATA_BYTES.
- NN_LATENCY, 1200, cycles from the nn_start pulse to a valid nn_label; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- s_data  input  8  incoming sample byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader can accept a byte.
- reshaped_test_data  output  8*DATA_BYTES  assembled sample vector to the core.
- nn_start  output  1  one-cycle start pulse to the core.
- nn_label  input  8  label from the core.
- label_out  output  8  captured label.
- label_valid  output  1  label_out valid.
- label_ready  input  1  host accepts label.
- busy  output  1  high in START, WAIT and RESULT.

Behaviour:
- Reset (rst=0, asynchronous), applies from any state including mid-load or mid-wait:
  - state=LOAD, byte counter=0, latency counter=0.
  - reshaped_test_data=0, label_out=0.
  - nn_start=0, label_valid=0, busy=0.
  - s_ready=1 from the first clock edge after rst deasserts.
- FSM has 4 states: LOAD, START, WAIT, RESULT.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready, byte index i = byte counter, and s_data is written to reshaped_test_data[8i+7:8i]. The first byte lands in bits [7:0]; the last byte lands in the MSBs.
  - Counter increments by 1 per accepted byte.
  - When byte DATA_BYTES-1 is accepted: counter->0, next state START.
  - No partial-sample timeout. Gaps in s_valid simply stall the load.
- START:
  - nn_start=1 for exactly this one cycle; s_ready=0.
  - Latency counter cleared to 0; next state WAIT.
- WAIT:
  - s_ready=0.
  - Latency counter increments every cycle.
  - When the counter equals NN_LATENCY-1: nn_label is sampled into label_out on that edge, and next state is RESULT.
  - The nn_label sample edge is NN_LATENCY cycles after the nn_start edge.
- RESULT:
  - label_valid=1; label_out held stable; s_ready=0.
  - On label_valid&label_ready: label_valid->0, next state LOAD.
  - label_ready while label_valid=0 has no effect.
- reshaped_test_data:
  - Stable (no writes) from START through RESULT.
  - Keeps its last contents after returning to LOAD until overwritten byte-by-byte.
- Combinational outputs:
  - s_ready and busy are decoded from state only, with no combinational path from s_valid or label_ready.
  - nn_start and label_valid are registered.
- Accepted bytes are never dropped; s_ready=0 outside LOAD.
- Throughput: 1 byte/cycle in LOAD. Minimum sample period is DATA_BYTES+1+NN_LATENCY+1 cycles with label_ready held high.
- Counters: byte counter is ceil(log2(DATA_BYTES)) bits; latency counter is 16 bits.

Test Plan:
1. Reset, then stream bytes 0x01..0x3E back-to-back (s_valid=1) -> s_ready drops after the 62nd byte; reshaped_test_data[7:0]=0x01 and [495:488]=0x3E; nn_start is high for exactly one cycle, on the cycle after the 62nd byte.
2. NN_LATENCY=1200, nn_label driven 0x07 -> label_out=0x07 and label_valid=1 on the cycle after the edge that is 1200 cycles after the nn_start edge; busy=1 throughout; changing nn_label to 0x03 afterwards does not alter label_out.
3. Hold label_ready=0 for 50 cycles in RESULT -> label_valid and label_out stay constant and s_ready=0; assert label_ready -> label_valid=0 and s_ready=1 the next cycle.
4. Stream 62 bytes with s_valid toggling 1/0 each cycle and random gaps -> exactly 62 bytes are captured in order; no byte is written twice; nn_start is a single pulse.
5. Assert rst=0 asynchronously mid-load after 30 bytes, and again mid-WAIT -> all outputs go to 0 immediately with no clock edge; after release, a fresh 62-byte load starts at index 0 and behaves per test 1.
6. NN_LATENCY=1, two consecutive samples with label_ready tied high -> each label is sampled on the edge after its nn_start; second-sample bytes overwrite the first sample's vector correctly.
